// File: rtl/booth_r4_pp_accum_if.sv
// Operand/product handshake bundle for booth_r4_pp_accum. digit_err exists only
// when BOOTH_DIGIT_CHECK_EN is defined; dbg_state mirrors the FSM for observation.
interface booth_r4_pp_accum_if #(
  parameter int WIDTH = 8
);
  localparam int NDIG = WIDTH / 2;

  // Handshake: a transfer happens on a rising clk edge where valid && ready are
  // both high. The source holds valid and its payload until that edge; the sink
  // may raise or drop ready at will; ready never waits on valid.
  logic                  in_valid;
  logic                  in_ready;
  logic [WIDTH-1:0]      a_in;
  logic [NDIG*3-1:0]     digits_in;
  logic                  out_valid;
  logic                  out_ready;
  logic [2*WIDTH-1:0]    p_out;
  logic                  busy;
  logic [1:0]            dbg_state;
`ifdef BOOTH_DIGIT_CHECK_EN
  logic                  digit_err;
`endif

  modport slave (
    input  in_valid, a_in, digits_in, out_ready,
    output in_ready, out_valid, p_out, busy, dbg_state
`ifdef BOOTH_DIGIT_CHECK_EN
    , output digit_err
`endif
  );

  modport master (
    output in_valid, a_in, digits_in, out_ready,
    input  in_ready, out_valid, p_out, busy, dbg_state
`ifdef BOOTH_DIGIT_CHECK_EN
    , input digit_err
`endif
  );
endinterface

// File: rtl/booth_r4_pp_accum.sv
// Sequential radix-4 Booth partial-product accumulator: one digit per clock.
// Optional illegal-digit flag (digit_err) is enabled with BOOTH_DIGIT_CHECK_EN.
module booth_r4_pp_accum #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  booth_r4_pp_accum_if.slave   bus
);
  localparam int NDIG = WIDTH / 2;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [PW-1:0]       a_q;
  logic [PW-1:0]       acc_q;
  logic [PW-1:0]       p_q;
  logic [NDIG*3-1:0]   dig_q;
  logic [CW-1:0]       cnt_q;
  logic                ov_q;

  logic [2:0]          cur_dig;
  logic [PW-1:0]       mag;
  logic [PW-1:0]       pp;
  logic [PW-1:0]       pp_sh;
  logic [PW-1:0]       sum;
  logic                last_dig;

  // Digit k of the registered multiplier is consumed in the cycle cnt_q == k.
  always_comb begin
    cur_dig = 3'b000;
    for (int k = 0; k < NDIG; k++) begin
      if (cnt_q == CW'(k)) cur_dig = dig_q[3*k +: 3];
    end
  end

  // one=two=1 falls through both selects and contributes zero.
  always_comb begin
    mag = '0;
    if (cur_dig[0] && !cur_dig[1]) mag = a_q;
    else if (cur_dig[1] && !cur_dig[0]) mag = a_q << 1;
    pp       = cur_dig[2] ? (~mag + PW'(1)) : mag;
    pp_sh    = pp << {cnt_q, 1'b0};
    sum      = acc_q + pp_sh;
    last_dig = (cnt_q == CW'(NDIG - 1));
  end

`ifdef BOOTH_DIGIT_CHECK_EN
  logic illegal;
  logic err_acc_q;
  logic err_q;

  assign illegal = cur_dig[0] && cur_dig[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_acc_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      if (state_q == IDLE && bus.in_valid) begin
        err_acc_q <= 1'b0;
      end else if (state_q == RUN) begin
        err_acc_q <= err_acc_q | illegal;
        if (last_dig) err_q <= err_acc_q | illegal;
      end
    end
  end

  assign bus.digit_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
      dig_q   <= '0;
      cnt_q   <= '0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= {{WIDTH{bus.a_in[WIDTH-1]}}, bus.a_in};
            dig_q   <= bus.digits_in;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          acc_q <= sum;
          cnt_q <= cnt_q + CW'(1);
          if (last_dig) begin
            p_q     <= sum;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Return to IDLE only; the next accept waits one cycle for in_ready.
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          ov_q    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = ov_q;
  assign bus.p_out     = p_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.dbg_state = state_q;
endmodule

// File: tb/tb_booth_r4_pp_accum.sv
// Bench for booth_r4_pp_accum (WIDTH=8): directed plan cases, random Booth-encoded
// and raw-digit operands, random backpressure, mid-operation reset.
module tb_booth_r4_pp_accum;
  localparam int W    = 8;
  localparam int NDIG = W / 2;

  logic clk;
  logic rst_n;

  booth_r4_pp_accum_if #(.WIDTH(W)) bus ();

  booth_r4_pp_accum #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [2*W-1:0] exp_q[$];
  logic           exp_err_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  logic           rand_bp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, expv);
    end
  endtask

  // ---------------- reference model ----------------
  // Multiplier value represented by a digit vector: sum of d_k * 4^k.
  function automatic int digits_value(input logic [NDIG*3-1:0] d);
    int x = 0;
    for (int k = 0; k < NDIG; k++) begin
      int m;
      logic [2:0] g;
      g = d[3*k +: 3];
      if (g[0] && !g[1]) m = 1;
      else if (g[1] && !g[0]) m = 2;
      else m = 0;
      if (g[2]) m = -m;
      x += m * (4 ** k);
    end
    return x;
  endfunction

  function automatic logic digits_illegal(input logic [NDIG*3-1:0] d);
    logic e = 1'b0;
    for (int k = 0; k < NDIG; k++) e |= (d[3*k] && d[3*k+1]);
    return e;
  endfunction

  function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [NDIG*3-1:0] d);
    int p;
    p = int'($signed(a)) * digits_value(d);
    return p[2*W-1:0];
  endfunction

  // Standard radix-4 recoding of a two's-complement multiplier.
  function automatic logic [NDIG*3-1:0] booth_enc(input logic [W-1:0] x);
    logic [W:0]        xe;
    logic [NDIG*3-1:0] d;
    xe = {x, 1'b0};
    d  = '0;
    for (int k = 0; k < NDIG; k++) begin
      int v;
      v = -2 * int'(xe[2*k+2]) + int'(xe[2*k+1]) + int'(xe[2*k]);
      d[3*k+2] = (v < 0);
      d[3*k+1] = (v == 2) || (v == -2);
      d[3*k]   = (v == 1) || (v == -1);
    end
    return d;
  endfunction

  // ---------------- driver ----------------
  int accept_cycle;
  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic send(input logic [W-1:0] a, input logic [NDIG*3-1:0] d,
                      input logic [2*W-1:0] expv, input logic push);
    int waited = 0;
    @(posedge clk); #1;
    bus.a_in      = a;
    bus.digits_in = d;
    bus.in_valid  = 1'b1;
    while (!bus.in_ready && waited < 200) begin
      @(posedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b0;
      return;
    end
    if (push) begin
      exp_q.push_back(expv);
      exp_err_q.push_back(digits_illegal(d));
    end
    @(posedge clk);
    accept_cycle = cycle;
    #1;
    bus.in_valid  = 1'b0;
    bus.a_in      = W'($urandom);
    bus.digits_in = (NDIG*3)'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'(bus.p_out), 32'hFFFF_FFFF);
      end else begin
        logic [2*W-1:0] e;
        logic           ee;
        e  = exp_q.pop_front();
        ee = exp_err_q.pop_front();
        check("p_out", 32'(bus.p_out), 32'(e));
`ifdef BOOTH_DIGIT_CHECK_EN
        check("digit_err", 32'(bus.digit_err), 32'(ee));
`else
        if (ee === 1'bx) check("err_model", 32'(ee), 32'd0);
`endif
      end
    end
  end

  // Random backpressure, changed away from the sampling edge.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.digits_in = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_p_out",     32'(bus.p_out),     32'd0);
    check("rst_busy",      32'(bus.busy),      32'd0);
`ifdef BOOTH_DIGIT_CHECK_EN
    check("rst_digit_err", 32'(bus.digit_err), 32'd0);
`endif
    rst_n = 1'b1;

    // Plan 1 with exact latency: out_valid appears NDIG edges after acceptance.
    send(8'd3, 12'h009, 16'h000F, 1'b1);
    for (int i = 1; i <= NDIG; i++) begin
      @(posedge clk); #1;
      check("latency_out_valid", 32'(bus.out_valid), 32'(i == NDIG));
      check("latency_cycles_busy", 32'(bus.busy), 32'd1);
    end
    drain();

    // Plan 2, 3 and illegal-digit case followed by a legal one.
    send(8'h80, 12'hC00, 16'h4000, 1'b1);
    send(8'h80, 12'h001, 16'hFF80, 1'b1);
    send(8'd7,  12'h924, 16'h0000, 1'b1);
    send(8'd5,  12'h003, 16'h0000, 1'b1);
    send(8'd5,  12'h009, 16'h0019, 1'b1);
    drain();

    // Backpressure in DONE: outputs hold, in_ready low, in_valid ignored.
    bus.out_ready = 1'b0;
    send(8'd6, 12'h00A, 16'h0024, 1'b1);
    begin
      int t = 0;
      while (!bus.out_valid && t < 50) begin
        @(posedge clk); #1;
        t++;
      end
    end
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = i[0];
      bus.a_in      = W'($urandom);
      bus.digits_in = (NDIG*3)'($urandom);
      @(posedge clk); #1;
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_p_out",     32'(bus.p_out),     32'h0024);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    check("bp_release_in_ready",  32'(bus.in_ready),  32'd1);
    check("bp_release_p_hold",    32'(bus.p_out),     32'h0024);
    send(8'hFD, 12'h009, 16'hFFF1, 1'b1);
    drain();

    // Reset during the second RUN cycle aborts with no result.
    send(8'd9, 12'h009, 16'h0000, 1'b0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_p_out",     32'(bus.p_out),     32'd0);
    check("abort_busy",      32'(bus.busy),      32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'd3, 12'h009, 16'h000F, 1'b1);
    drain();

    // Random: Booth-encoded multipliers against the plain integer product.
    rand_bp = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] a, x;
      int           p;
      a = W'($urandom);
      x = W'($urandom);
      if (i == 0) begin a = 8'h80; x = 8'h80; end
      p = int'($signed(a)) * int'($signed(x));
      send(a, booth_enc(x), p[2*W-1:0], 1'b1);
    end
    // Random raw digits, including illegal and -0 codes.
    for (int i = 0; i < 30; i++) begin
      logic [W-1:0]      a;
      logic [NDIG*3-1:0] d;
      a = W'($urandom);
      d = (NDIG*3)'($urandom);
      send(a, d, model(a, d), 1'b1);
    end
    drain();
    rand_bp = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/booth_r4_pp_accum.md
Name: booth_r4_pp_accum

Overview:
- Sequential radix-4 Booth partial-product generator and accumulator.
- Sits directly downstream of the radix-4 Booth encoder. It consumes the encoder's packed 3-bit digits {neg, two, one} for a two's-complement multiplier X, together with a signed multiplicand A.
- Each cycle it selects one partial product from {0, ±A, ±2A}, weights it and accumulates it. The full 2*WIDTH signed product A*X is returned over a valid/ready handshake.
- One digit is processed per clock, giving a compact multiplier with no partial-product tree.

Parameters:
- WIDTH, 8: multiplicand/multiplier width in bits; must be even and ≥4. Derived: NDIG = WIDTH/2 digits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block can accept operands; equals (state==IDLE).
- a_in  in  WIDTH  signed multiplicand A.
- digits_in  in  NDIG*3  Booth digits. Digit k occupies bits [3k+2:3k] as {neg=3k+2, two=3k+1, one=3k}.
- out_valid  out  1  product valid.
- out_ready  in  1  downstream accepts product.
- p_out  out  2*WIDTH  signed product A*X.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, acc=0, cnt=0, out_valid=0, p_out=0, busy=0.
  - in_ready reads 1 while in reset, but transfers are ignored until rst_n=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE: on in_valid&&in_ready, register A (sign-extended to 2*WIDTH) and digits_in; set acc=0, cnt=0; go to RUN.
  - RUN: each cycle, acc <= acc + (pp_k << 2k), with k=cnt, then cnt++. After digit NDIG-1 is added, load p_out from the final sum, set out_valid=1, go to DONE.
  - DONE: hold p_out and out_valid stable until out_ready=1, then clear out_valid and go to IDLE. No new accept in the same cycle; in_ready rises the cycle after.
- Latency: with acceptance at edge T, out_valid=1 after edge T+NDIG. Throughput is one product per NDIG+2 cycles with out_ready tied high.
- in_valid is ignored outside IDLE; a_in and digits_in are sampled only on the acceptance edge.
- Partial-product selection, pp_k:
  - one=1, two=0: magnitude A.
  - two=1, one=0: magnitude 2A.
  - one=two=0: magnitude 0.
  - one=two=1 (illegal): magnitude 0.
  - neg=1: two's-complement negate the magnitude. neg with magnitude 0 gives 0.
- All arithmetic is 2*WIDTH bits, wrapping modulo 2^(2*WIDTH). A legal digit set yields the exact signed product, including A=X=-2^(WIDTH-1).
- p_out changes only on the RUN→DONE transition; it retains its last value in IDLE.
- Reset mid-RUN or mid-DONE aborts the operation. All outputs return to reset values and no result is produced.

Optional Feature:
- Macro: BOOTH_DIGIT_CHECK_EN.
- Defined: adds output port digit_err (1 bit). digit_err is loaded alongside p_out and is 1 if any consumed digit had one=two=1 (sticky within the transaction); it resets to 0.
- Not defined: port absent, no check logic.
- Datapath result is identical either way; illegal digits always contribute 0.

Test Plan (WIDTH=8):
1. a_in=3, digits_in=12'h009 (X=5) -> out_valid 4 cycles after acceptance; p_out=16'h000F.
2. a_in=8'h80, digits_in=12'hC00 (X=-128, top digit -2) -> p_out=16'h4000; also check a_in=8'h80 with digits_in=12'h001 (X=+1) -> p_out=16'hFF80.
3. a_in=7, digits_in=12'h924 (all digits -0) -> p_out=16'h0000.
4. Backpressure: hold out_ready=0 for 5 cycles in DONE -> p_out/out_valid stable, in_ready=0, in_valid pulses ignored. Release out_ready -> IDLE next cycle, following transaction (a_in=-3, digits_in=12'h009) gives p_out=16'hFFF1.
5. Deassert rst_n during the 2nd RUN cycle -> out_valid=0, p_out=0, busy=0 immediately. After release, a_in=3/digits_in=12'h009 gives 16'h000F.
6. a_in=5, digits_in=12'h003 (illegal digit k0) -> p_out=16'h0000. With BOOTH_DIGIT_CHECK_EN: digit_err=1; next legal transaction clears it to 0.
